// File: rtl/pak_pkg.sv
// Shared definitions for the pak sample-processing blocks: register map,
// CTRL field layout and the common signed sample type.
package pak_pkg;

  localparam int unsigned PAK_DATA_WIDTH = 16;

  localparam logic [5:0] PAK_DECIM_CTRL      = 6'h00;
  localparam logic [5:0] PAK_DECIM_STATUS    = 6'h01;
  localparam logic [5:0] PAK_DECIM_OUT_COUNT = 6'h02;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_LOG2R_LSB = 4;
  localparam int unsigned CTRL_LOG2R_W   = 4;

  typedef logic signed [PAK_DATA_WIDTH-1:0] pak_sample_t;

endpackage

// File: rtl/pak_sync_fifo.sv
// Single-clock shifting FIFO; entry 0 is the registered head so dout is a flop.
// Simultaneous push and pop are both honoured.
module pak_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = IDX_W + 1;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [LVL_W-1:0]      level_q, level_d;
  logic [IDX_W-1:0]      wr_idx_c;
  logic                  do_pop_c, do_push_c;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);

  // On pop everything shifts toward the head, so a same-cycle push lands one slot lower.
  always_comb begin
    data_d   = data_q;
    level_d  = level_q;
    wr_idx_c = IDX_W'(level_q);
    if (do_pop_c) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        data_d[i] = data_q[i+1];
      end
      wr_idx_c = IDX_W'(level_q - LVL_W'(1));
    end
    if (do_push_c) begin
      data_d[wr_idx_c] = din;
    end
    level_d = level_q + LVL_W'(do_push_c) - LVL_W'(do_pop_c);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      level_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      data_q  <= data_d;
    end
  end

  assign dout  = data_q[0];
  assign level = level_q;

endmodule

// File: rtl/pak_decim_avg.sv
// Boxcar average-and-dump decimator: sums 2^k samples, rounds half up,
// scales back to sample width and queues one result per group.
module pak_decim_avg
  import pak_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_LOG2R  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [5:0]            addr,
  input  logic                  write_en,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata,
  input  logic [DATA_WIDTH-1:0] src_data_in,
  input  logic                  src_valid_in,
  output logic                  src_ready_out,
  output logic [DATA_WIDTH-1:0] dst_data_out,
  output logic                  dst_valid_out,
  input  logic                  dst_ready_in
);

  localparam int unsigned ACC_W = DATA_WIDTH + MAX_LOG2R;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned PH_W  = MAX_LOG2R;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned K_W   = CTRL_LOG2R_W;

  logic                    en_q, en_d;
  logic [K_W-1:0]          log2r_q, log2r_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [15:0]             out_cnt_q, out_cnt_d;

  logic                    ctrl_wr_c, cnt_wr_c, accept_c, push_c, pop_c;
  logic                    fifo_full_c, fifo_empty_c;
  logic [LVL_W-1:0]        fifo_level_c;
  logic [K_W-1:0]          wr_log2r_c;
  logic [PH_W-1:0]         phase_last_c;
  logic signed [DATA_WIDTH-1:0] sample_c;
  logic signed [SUM_W-1:0] rnd_c, sum_c;
  logic [DATA_WIDTH-1:0]   result_c;
  logic                    unused_wdata_c;

  assign ctrl_wr_c      = write_en && (addr == PAK_DECIM_CTRL);
  assign cnt_wr_c       = write_en && (addr == PAK_DECIM_OUT_COUNT);
  assign src_ready_out  = en_q && !fifo_full_c;
  assign dst_valid_out  = !fifo_empty_c;
  assign accept_c       = src_valid_in && src_ready_out;
  assign pop_c          = dst_valid_out && dst_ready_in;
  assign wr_log2r_c     = wdata[CTRL_LOG2R_LSB +: CTRL_LOG2R_W];
  assign unused_wdata_c = ^{wdata[15:8], wdata[3:1]};

  // Group boundary and round-half-up result for the current k.
  assign sample_c     = $signed(src_data_in);
  assign phase_last_c = ~({PH_W{1'b1}} << log2r_q);
  assign rnd_c        = (log2r_q == '0) ? '0
                        : $signed(SUM_W'(1) << (log2r_q - K_W'(1)));
  assign sum_c        = SUM_W'(acc_q) + SUM_W'(sample_c) + rnd_c;
  assign result_c     = DATA_WIDTH'(sum_c >>> log2r_q);

  // Register file next-state.
  always_comb begin
    en_d      = en_q;
    log2r_d   = log2r_q;
    out_cnt_d = out_cnt_q;
    if (ctrl_wr_c) begin
      en_d    = wdata[CTRL_EN_BIT];
      log2r_d = (wr_log2r_c > K_W'(MAX_LOG2R)) ? K_W'(MAX_LOG2R) : wr_log2r_c;
    end
    if (cnt_wr_c) begin
      out_cnt_d = '0;
    end else if (pop_c) begin
      out_cnt_d = out_cnt_q + 16'd1;
    end
  end

  // A CTRL write or disable discards the partial group, including a completing sample.
  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    push_c  = 1'b0;
    if (ctrl_wr_c || !en_q) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (accept_c) begin
      if (phase_q == phase_last_c) begin
        push_c  = 1'b1;
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = acc_q + ACC_W'(sample_c);
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      en_q      <= 1'b0;
      log2r_q   <= '0;
      acc_q     <= '0;
      phase_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      en_q      <= en_d;
      log2r_q   <= log2r_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      PAK_DECIM_CTRL: begin
        rdata[CTRL_EN_BIT]                       = en_q;
        rdata[CTRL_LOG2R_LSB +: CTRL_LOG2R_W]    = log2r_q;
      end
      PAK_DECIM_STATUS: begin
        rdata[4:0]  = 5'(fifo_level_c);
        rdata[11:8] = 4'(phase_q);
      end
      PAK_DECIM_OUT_COUNT: rdata = out_cnt_q;
      default: ;
    endcase
  end

  pak_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push_c),
    .din    (result_c),
    .pop    (pop_c),
    .dout   (dst_data_out),
    .full   (fifo_full_c),
    .empty  (fifo_empty_c),
    .level  (fifo_level_c)
  );

endmodule

// File: tb/tb_pak_decim_avg.sv
// Scoreboard bench for pak_decim_avg: a behavioural model queues expected
// averages on each accepted sample; outputs are popped and compared on handshake.
module tb_pak_decim_avg;
  import pak_pkg::*;

  logic        clk;
  logic        arst_n;
  logic [5:0]  addr;
  logic        write_en;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [15:0] src_data_in;
  logic        src_valid_in;
  logic        src_ready_out;
  logic [15:0] dst_data_out;
  logic        dst_valid_out;
  logic        dst_ready_in;

  int n_checks = 0;
  int n_errors = 0;

  pak_sample_t exp_q[$];
  int          m_acc, m_phase, m_k;
  logic [15:0] m_cnt;

  pak_decim_avg #(.DATA_WIDTH(16), .MAX_LOG2R(4), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .addr          (addr),
    .write_en      (write_en),
    .wdata         (wdata),
    .rdata         (rdata),
    .src_data_in   (src_data_in),
    .src_valid_in  (src_valid_in),
    .src_ready_out (src_ready_out),
    .dst_data_out  (dst_data_out),
    .dst_valid_out (dst_valid_out),
    .dst_ready_in  (dst_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model and output scoreboard, evaluated mid-cycle ahead of the next posedge.
  always @(negedge clk) begin
    if (!arst_n) begin
      m_acc = 0; m_phase = 0; m_k = 0; m_cnt = '0;
      exp_q.delete();
    end else begin
      if (dst_valid_out && dst_ready_in) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", dst_data_out, 16'hxxxx);
        end else begin
          check_eq("dout", dst_data_out, exp_q.pop_front());
        end
        m_cnt = m_cnt + 16'd1;
      end
      if (write_en && addr == PAK_DECIM_OUT_COUNT) m_cnt = '0;
      if (write_en && addr == PAK_DECIM_CTRL) begin
        m_k     = (int'(wdata[7:4]) > 4) ? 4 : int'(wdata[7:4]);
        m_acc   = 0;
        m_phase = 0;
      end else if (src_valid_in && src_ready_out) begin
        int s, rnd, res;
        s   = int'(pak_sample_t'(src_data_in));
        rnd = (m_k == 0) ? 0 : (1 << (m_k - 1));
        if (m_phase == (1 << m_k) - 1) begin
          res = (m_acc + s + rnd) >>> m_k;
          assert (res >= -32768 && res <= 32767) else $error("average out of sample range");
          exp_q.push_back(pak_sample_t'(res));
          m_acc   = 0;
          m_phase = 0;
        end else begin
          m_acc   = m_acc + s;
          m_phase = m_phase + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [15:0] d);
    addr = a; wdata = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [5:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    check_eq(tag, rdata, exp);
  endtask

  task automatic send(input pak_sample_t s);
    bit ok = 1'b0;
    tick();
    src_data_in  = s;
    src_valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (src_ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout", 16'd0, 16'd1);
    tick();
    src_valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check_eq("drain", 16'(exp_q.size()), 16'd0);
    tick();
    tick();
  endtask

  initial begin
    arst_n = 1'b0; addr = '0; write_en = 1'b0; wdata = '0;
    src_data_in = '0; src_valid_in = 1'b0; dst_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_src_ready", 16'(src_ready_out), 16'd0);
    check_eq("rst_dst_valid", 16'(dst_valid_out), 16'd0);
    check_eq("rst_dst_data", dst_data_out, 16'd0);
    check_eq("rst_rdata", rdata, 16'd0);
    arst_n = 1'b1;
    tick();

    // k=0 pass-through with one-cycle latency
    dst_ready_in = 1'b1;
    reg_write(PAK_DECIM_CTRL, 16'h0001);
    send(16'sd100);
    @(negedge clk);
    check_eq("lat_valid", 16'(dst_valid_out), 16'd1);
    check_eq("lat_data", dst_data_out, 16'd100);
    send(-16'sd5);
    drain();
    rd_check("out_count_2", PAK_DECIM_OUT_COUNT, 16'd2);

    // k=2 rounding, positive and negative groups
    reg_write(PAK_DECIM_CTRL, 16'h0021);
    for (int i = 1; i <= 4; i++) send(pak_sample_t'(i));
    for (int i = 1; i <= 4; i++) send(pak_sample_t'(-i));
    drain();

    // k clamps to 4; full-scale extremes
    reg_write(PAK_DECIM_CTRL, 16'h00F1);
    rd_check("ctrl_clamp", PAK_DECIM_CTRL, 16'h0041);
    repeat (16) send(16'sd32767);
    repeat (16) send(-16'sd32768);
    drain();

    // FIFO full backpressure with k=0
    reg_write(PAK_DECIM_CTRL, 16'h0001);
    dst_ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) send(pak_sample_t'(11 * i));
    check_eq("full_ready", 16'(src_ready_out), 16'd0);
    rd_check("full_status", PAK_DECIM_STATUS, 16'h0004);
    src_data_in = 16'd55; src_valid_in = 1'b1;
    repeat (5) tick();
    rd_check("full_status_held", PAK_DECIM_STATUS, 16'h0004);
    check_eq("hold_valid", 16'(dst_valid_out), 16'd1);
    check_eq("hold_data", dst_data_out, 16'd11);
    src_valid_in = 1'b0;
    dst_ready_in = 1'b1;
    send(16'sd55);
    send(16'sd66);
    drain();

    // CTRL write mid-group discards the partial sum
    reg_write(PAK_DECIM_CTRL, 16'h0021);
    send(16'sd1);
    send(16'sd2);
    rd_check("mid_phase", PAK_DECIM_STATUS, 16'h0200);
    reg_write(PAK_DECIM_CTRL, 16'h0011);
    send(16'sd5);
    send(16'sd7);
    drain();
    rd_check("phase_cleared", PAK_DECIM_STATUS, 16'h0000);
    rd_check("out_count_model", PAK_DECIM_OUT_COUNT, m_cnt);
    reg_write(PAK_DECIM_OUT_COUNT, 16'h1234);
    rd_check("out_count_clear", PAK_DECIM_OUT_COUNT, 16'd0);

    // Asynchronous reset mid-group with FIFO occupied
    dst_ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) send(pak_sample_t'(i));
    rd_check("pre_rst_status", PAK_DECIM_STATUS, 16'h0102);
    arst_n = 1'b0;
    #1;
    check_eq("arst_dst_valid", 16'(dst_valid_out), 16'd0);
    check_eq("arst_dst_data", dst_data_out, 16'd0);
    check_eq("arst_src_ready", 16'(src_ready_out), 16'd0);
    rd_check("arst_ctrl", PAK_DECIM_CTRL, 16'd0);
    rd_check("arst_status", PAK_DECIM_STATUS, 16'd0);
    rd_check("arst_count", PAK_DECIM_OUT_COUNT, 16'd0);
    @(negedge clk);
    tick();
    arst_n = 1'b1;
    dst_ready_in = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_ready", 16'(src_ready_out), 16'd0);
    reg_write(PAK_DECIM_CTRL, 16'h0001);
    check_eq("reenable_ready", 16'(src_ready_out), 16'd1);
    send(16'sd9);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pak_decim_avg.md
# pak_decim_avg

Boxcar average-and-dump decimator sitting directly downstream of `pak_dsp`: consumes the filtered sample stream from `pak_dsp`'s `dst_*` port. Sums each group of R = 2^k samples, rounds and scales the sum back to DATA_WIDTH, and emits one sample per group through a small output FIFO with valid/ready handshakes. Configured and observed through the same `addr`/`write_en`/`wdata`/`rdata` register-bus style as `pak_dsp`.

## Interface
- `DATA_WIDTH`, 16, signed sample width in and out
- `MAX_LOG2R`, 4, largest decimation exponent k (R max = 16)
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥2)
- `clk` input 1 — single clock, all logic on posedge
- `arst_n` input 1 — asynchronous active-low reset
- `addr` input 6 — register address
- `write_en` input 1 — register write strobe, sampled on posedge
- `wdata` input 16 — register write data
- `rdata` output 16 — register read data, combinational from `addr`
- `src_data_in` input DATA_WIDTH — signed input sample (from `pak_dsp` `dst_data_out`)
- `src_valid_in` input 1 — input sample valid
- `src_ready_out` output 1 — block can accept a sample
- `dst_data_out` output DATA_WIDTH — signed decimated sample
- `dst_valid_out` output 1 — output sample valid
- `dst_ready_in` input 1 — consumer accepts output

## Operation
- Registers:
  - 0x00 CTRL, RW: [0] `en`, [7:4] `log2r`. Writes > MAX_LOG2R store MAX_LOG2R. Reset value 0x0000.
  - 0x01 STATUS, RO: [4:0] FIFO level, [11:8] phase counter.
  - 0x02 OUT_COUNT, RW: 16-bit count of output handshakes, wraps at 0xFFFF→0. Any write clears it to 0.
  - Other addresses read 0; writes to them are ignored.
- Input accept: occurs when `src_valid_in && src_ready_out` at posedge.
- `src_ready_out = en && !fifo_full`. This guarantees that every group completion can push into the FIFO.
- Accumulator: signed, width DATA_WIDTH+MAX_LOG2R. Phase counter 0..R-1.
- On each accept with phase < R-1: acc += sample, phase++.
- On the accept with phase == R-1:
  - result = (acc + sample + rnd) >>> k, where rnd = 2^(k-1) for k>0 and 0 for k=0. Round half toward +inf.
  - result is pushed to the FIFO; acc and phase are cleared.
  - The result always fits in DATA_WIDTH, so no saturation logic is needed. Bench asserts this.
- k = 0 gives pass-through with FIFO latency.
- Any CTRL write (even unchanged value) clears acc and phase, discarding the partial group. FIFO contents are kept.
- `en` = 0: ready low, acc/phase held cleared. FIFO keeps draining normally.
- FIFO push and pop in the same cycle are both honoured; level is unchanged.
- An output handshake (`dst_valid_out && dst_ready_in`) pops the FIFO and increments OUT_COUNT.
- A CTRL write in the same cycle as a group-completing accept: the write wins, and the sample is discarded with the group.

## Timing
- Reset values: `src_ready_out`=0, `dst_valid_out`=0, `dst_data_out`=0, `rdata`=0 (addr 0 decode of reset CTRL). FIFO empty, acc=0, phase=0, OUT_COUNT=0.
- Latency: group completes at posedge t → `dst_valid_out` high after posedge t (visible cycle t+1) if the FIFO was empty.
- `dst_data_out` is driven from the FIFO head register.
- `dst_data_out`/`dst_valid_out` remain stable while `dst_valid_out && !dst_ready_in`.
- `src_ready_out` falls on the cycle after the push that fills the FIFO. It rises on the cycle after the pop that frees a slot.
- A register write takes effect at the posedge of `write_en`. `rdata` reflects the new value in the next cycle.
- Reset asserted mid-operation clears all state immediately, with no handshake.

## Structure
- `pak_pkg` holds:
  - register address localparams (`PAK_DECIM_CTRL`=0x00, `_STATUS`=0x01, `_OUT_COUNT`=0x02)
  - CTRL field bit positions
  - a typedef for the signed sample type shared with `pak_dsp`
- Sub-module `pak_sync_fifo` (DATA_WIDTH, DEPTH): single-clock, registered head, `full`/`empty`/`level`, simultaneous push/pop. Reusable as a skid buffer elsewhere.
- The top level contains the register file, accumulator/phase datapath and handshake glue.

## Test plan
- k=0, en=1, inputs 100, −5 with `dst_ready_in`=1 → outputs 100, −5, each one cycle after accept; OUT_COUNT=2.
- k=2, inputs 1,2,3,4 then −1,−2,−3,−4 → outputs 3 ((10+2)>>>2) and −2 ((−10+2)>>>2).
- k=4, sixteen 32767 → 32767; sixteen −32768 → −32768.
- k=0, `dst_ready_in`=0, offer 6 samples → exactly 4 accepted, `src_ready_out`=0, STATUS level=4. Then release `dst_ready_in` → outputs drain in order and the last 2 samples are accepted.
- k=2, send 1,2, then write CTRL with k=1, then send 5,7 → single output 6 ((12+1)>>>1); STATUS phase=0 afterward.
- Mid-group and with FIFO non-empty, pulse `arst_n` low → all outputs 0, level 0, CTRL reads 0, `src_ready_out`=0 until en is rewritten.
